compress_pipe: RTL and testbench

- Pipelined ML-KEM Compress_d stage; sits directly upstream of `barrett_reduction` and instantiates it.
- Forms the rounding dividend (x << d) + floor(q/2) and feeds it to the reducer.
- Takes the quotient output and returns it masked to d bits: Compress_d(x) = round(2^d·x/q) mod 2^d.
- Valid/ready streaming, 1 coefficient/cycle throughput, fixed 2-cycle latency; used in ciphertext/public-key encode paths.

---
 rtl/barrett_reduction.sv | 36 +++
 rtl/compress_pipe.sv | 108 ++++++++++
 tb/tb_compress_pipe.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/barrett_reduction.sv
// rtl/barrett_reduction.sv - combinational Barrett divider: inv = floor(x/PRIME), r = x mod PRIME
module barrett_reduction #(
    parameter int PRIME    = 3329,
    parameter int REG_SIZE = $clog2(PRIME)
) (
    input  logic [2*REG_SIZE-1:0] x,
    output logic [REG_SIZE-1:0]   r,
    output logic [2*REG_SIZE-1:0] inv
);
    localparam int DIVW = 2 * REG_SIZE;
    localparam logic [DIVW-1:0] QW = DIVW'(PRIME);
    localparam logic [DIVW-1:0] MU = DIVW'((64'd1 << DIVW) / 64'(PRIME));

    logic [DIVW-1:0] q0;
    logic [DIVW-1:0] r0;
    logic [DIVW-1:0] r_acc;
    logic [DIVW-1:0] q_acc;

    assign q0 = DIVW'(({{DIVW{1'b0}}, x} * {{DIVW{1'b0}}, MU}) >> DIVW);
    assign r0 = x - DIVW'(q0 * QW);

    // The truncated estimate undershoots the true quotient by at most two
    always_comb begin
        r_acc = r0;
        q_acc = q0;
        for (int i = 0; i < 2; i++) begin
            if (r_acc >= QW) begin
                r_acc = r_acc - QW;
                q_acc = q_acc + DIVW'(1);
            end
        end
    end

    assign r   = REG_SIZE'(r_acc);
    assign inv = q_acc;
endmodule

// File: rtl/compress_pipe.sv
// rtl/compress_pipe.sv - two-stage ML-KEM Compress_d pipeline with valid/ready handshake
module compress_pipe #(
    parameter int PRIME    = 3329,
    parameter int REG_SIZE = $clog2(PRIME),
    parameter int D_MAX    = 11,
    parameter int DW       = 4
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                zeroize,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [REG_SIZE-1:0] in_data,
    input  logic [DW-1:0]       in_d,
    input  logic                in_last,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [REG_SIZE-1:0] out_data,
    output logic                out_last,
    output logic                out_err,
    output logic                busy
);
    localparam int DIVW = 2 * REG_SIZE;

    logic                ready_en;
    logic                s1_valid;
    logic [DIVW-1:0]     s1_div;
    logic [DW-1:0]       s1_d;
    logic                s1_last;
    logic                s1_err;

    logic                s2_adv;
    logic                s1_adv;
    logic                accept;
    logic                err_in;
    logic [DIVW-1:0]     div_in;
    logic [DIVW-1:0]     quot;
    logic [REG_SIZE-1:0] unused_r;
    logic                unused_bits;
    logic [REG_SIZE-1:0] mask;

    assign s2_adv   = !out_valid || out_ready;
    assign s1_adv   = !s1_valid || s2_adv;
    assign in_ready = ready_en && !zeroize && s1_adv;
    assign accept   = in_valid && in_ready;
    assign busy     = s1_valid || out_valid;

    assign err_in = (in_d == '0) || (in_d > DW'(D_MAX)) || (in_data >= REG_SIZE'(PRIME));
    assign div_in = err_in ? '0 : (DIVW'(in_data) << in_d) + DIVW'(PRIME >> 1);
    assign mask   = (REG_SIZE'(1) << s1_d) - REG_SIZE'(1);

    barrett_reduction #(
        .PRIME    (PRIME),
        .REG_SIZE (REG_SIZE)
    ) u_barrett (
        .x   (s1_div),
        .r   (unused_r),
        .inv (quot)
    );

    // Only the quotient feeds the result; the remainder and high quotient bits are dropped
    assign unused_bits = ^{unused_r, quot[DIVW-1:REG_SIZE]};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ready_en  <= 1'b0;
            s1_valid  <= 1'b0;
            s1_div    <= '0;
            s1_d      <= '0;
            s1_last   <= 1'b0;
            s1_err    <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            out_err   <= 1'b0;
        end else if (zeroize) begin
            ready_en  <= 1'b1;
            s1_valid  <= 1'b0;
            s1_div    <= '0;
            s1_d      <= '0;
            s1_last   <= 1'b0;
            s1_err    <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            out_err   <= 1'b0;
        end else begin
            ready_en <= 1'b1;
            if (s1_adv) begin
                s1_valid <= accept;
                if (accept) begin
                    s1_div  <= div_in;
                    s1_d    <= in_d;
                    s1_last <= in_last;
                    s1_err  <= err_in;
                end
            end
            if (s2_adv) begin
                out_valid <= s1_valid;
                if (s1_valid) begin
                    out_data <= s1_err ? '0 : (quot[REG_SIZE-1:0] & mask);
                    out_last <= s1_last;
                    out_err  <= s1_err;
                end
            end
        end
    end
endmodule

// File: tb/tb_compress_pipe.sv
// tb/tb_compress_pipe.sv - randomized and directed self-checking bench for compress_pipe
module tb_compress_pipe;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        zeroize = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [11:0] in_data = '0;
    logic [3:0]  in_d = '0;
    logic        in_last = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [11:0] out_data;
    logic        out_last;
    logic        out_err;
    logic        busy;

    compress_pipe dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .zeroize   (zeroize),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_d      (in_d),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_err   (out_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int data;
        bit last;
        bit err;
        int cyc;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   n_acc = 0;
    bit   check_lat = 0;
    bit   expect_block = 0;
    bit   hold_pending = 0;
    int   hold_data = 0;
    bit   hold_last = 0;
    bit   hold_err = 0;

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic exp_t model(input int x, input int d, input bit last, input int c);
        exp_t m;
        m.last = last;
        m.cyc  = c;
        m.err  = (d < 1) || (d > 11) || (x >= 3329);
        m.data = m.err ? 0 : (((x * (1 << d)) + 1664) / 3329) % (1 << d);
        return m;
    endfunction

    // Called at a negedge with inputs already set; samples just before the next posedge
    task automatic tick();
        bit   acc;
        bit   drn;
        exp_t e;
        #4;
        acc = in_valid && in_ready;
        drn = out_valid && out_ready;
        if (expect_block) chk("bp_in_ready", int'(in_ready), 0);
        if (hold_pending) begin
            chk("hold_valid", int'(out_valid), 1);
            chk("hold_data", int'(out_data), hold_data);
            chk("hold_last", int'(out_last), int'(hold_last));
            chk("hold_err", int'(out_err), int'(hold_err));
        end
        if (drn) begin
            if (exp_q.size() == 0) begin
                chk("stale_out", 1, 0);
            end else begin
                e = exp_q.pop_front();
                chk("data", int'(out_data), e.data);
                chk("last", int'(out_last), int'(e.last));
                chk("err", int'(out_err), int'(e.err));
                if (check_lat) chk("latency", cyc - e.cyc, 2);
            end
        end
        if (acc) begin
            exp_q.push_back(model(int'(in_data), int'(in_d), in_last, cyc));
            n_acc++;
        end
        hold_pending = out_valid && !out_ready && !zeroize;
        hold_data    = int'(out_data);
        hold_last    = out_last;
        hold_err     = out_err;
        if (zeroize) exp_q.delete();
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic send(input int x, input int d, input bit last);
        int guard;
        int start;
        in_valid = 1'b1;
        in_data  = 12'(x);
        in_d     = 4'(d);
        in_last  = last;
        start    = n_acc;
        guard    = 0;
        while (n_acc == start && guard < 50) begin
            tick();
            guard++;
        end
        if (n_acc == start) chk("send_timeout", 0, 1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int guard;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        guard = 0;
        while ((exp_q.size() != 0 || busy) && guard < 200) begin
            tick();
            guard++;
        end
        chk("drained", exp_q.size(), 0);
    endtask

    task automatic send_burst(input int xs[], input int ds[]);
        for (int i = 0; i < xs.size(); i++) begin
            in_valid = 1'b1;
            in_data  = 12'(xs[i]);
            in_d     = 4'(ds[i]);
            in_last  = (i == xs.size() - 1);
            tick();
        end
        in_valid = 1'b0;
    endtask

    int bp_x[8] = '{5, 100, 832, 1665, 2000, 2500, 3000, 3328};
    int bp_d[8] = '{1, 4, 5, 10, 11, 4, 1, 11};
    int dsel[5] = '{1, 4, 5, 10, 11};

    initial begin
        // Reset state
        @(negedge clk);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_out_data", int'(out_data), 0);
        chk("rst_in_ready", int'(in_ready), 0);
        @(negedge clk);
        reset_n = 1'b1;
        tick();
        chk("ready_after_reset", int'(in_ready), 1);

        // Rounding boundaries at d=1, full throughput, fixed latency
        out_ready = 1'b1;
        check_lat = 1;
        send_burst('{0, 832, 833, 1665, 3000, 3328}, '{1, 1, 1, 1, 1, 1});
        drain();

        // Mixed widths on consecutive cycles
        send_burst('{1000, 3328, 1664, 1}, '{4, 11, 11, 10});
        drain();

        // Illegal inputs followed by a legal one
        send_burst('{100, 200, 3329, 1000}, '{0, 12, 4, 4});
        drain();
        check_lat = 0;

        // Backpressure: 8 inputs with out_ready low for 5 cycles
        begin
            int c;
            int start;
            start = n_acc;
            c = 0;
            while ((n_acc - start) < 8 && c < 60) begin
                in_valid     = 1'b1;
                in_data      = 12'(bp_x[n_acc - start]);
                in_d         = 4'(bp_d[n_acc - start]);
                in_last      = ((n_acc - start) == 7);
                out_ready    = (c >= 5);
                expect_block = (c < 5) && ((n_acc - start) >= 2);
                tick();
                c++;
            end
            expect_block = 0;
            chk("bp_all_accepted", n_acc - start, 8);
            drain();
        end

        // Zeroize with two coefficients in flight
        out_ready = 1'b0;
        send(10, 4, 0);
        send(20, 4, 1);
        zeroize = 1'b1;
        tick();
        zeroize = 1'b0;
        chk("zero_out_valid", int'(out_valid), 0);
        chk("zero_busy", int'(busy), 0);
        chk("zero_out_data", int'(out_data), 0);
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        chk("zero_no_stale", int'(busy), 0);

        // Asynchronous reset pulse between clock edges
        out_ready = 1'b0;
        send(3328, 11, 0);
        send(1664, 11, 1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_out_valid", int'(out_valid), 0);
        chk("arst_busy", int'(busy), 0);
        chk("arst_out_data", int'(out_data), 0);
        chk("arst_out_last", int'(out_last), 0);
        exp_q.delete();
        hold_pending = 0;
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        chk("arst_ready_low", int'(in_ready), 0);
        #1;
        tick();
        chk("arst_ready_high", int'(in_ready), 1);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        chk("arst_no_stale", int'(busy), 0);

        // Random sweep with random backpressure
        begin
            int start;
            int guard;
            start = n_acc;
            guard = 0;
            while ((n_acc - start) < 10000 && guard < 60000) begin
                in_valid  = ($urandom % 4) != 0;
                in_data   = 12'($urandom_range(0, 3328));
                in_d      = 4'(dsel[$urandom % 5]);
                in_last   = 1'($urandom % 2);
                out_ready = ($urandom % 4) != 0;
                tick();
                guard++;
            end
            chk("rand_count", n_acc - start, 10000);
            drain();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
